// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with stall-vector bubble/hold control and flush.
// It also holds the madd/msub partial accumulator and cycle count across an EX self-stall.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   stall          per-stage stall vector from ctrl. stall[STALL_IDX] stalls EX and
//                  stall[STALL_IDX+1] stalls MEM.
//   flush          exception flush; kills the EX instruction and any madd/msub in flight
//   ex_*           GPR/HI-LO write fields, madd/msub count and partial product from EX
//   mem_*          registered GPR/HI-LO write fields; mem_valid=0 marks a bubble
//   cnt_o, hilo_o  madd/msub progress returned to EX on the next cycle
//   bubble_cnt     saturating count of bubble cycles (only with EX_MEM_STAT_EN)
//   hold_cnt       saturating count of hold cycles (only with EX_MEM_STAT_EN)
//
// Build option: define EX_MEM_STAT_EN to add the two statistics counters.
// Without it, both counters are tied to zero. The port list is the same in both builds.
module ex_mem_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int STALL_W   = 6,
  parameter int STALL_IDX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [1:0]          ex_cnt,
  input  logic [2*DATA_W-1:0] ex_hilo_temp,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic                mem_valid,
  output logic [1:0]          cnt_o,
  output logic [2*DATA_W-1:0] hilo_o,
  output logic [31:0]         bubble_cnt,
  output logic [31:0]         hold_cnt
);

  typedef struct packed {
    logic [ADDR_W-1:0] wd;
    logic              wreg;
    logic [DATA_W-1:0] wdata;
    logic              whilo;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
  } mem_t;

  mem_t                mem_q, mem_d, ex_in;
  logic                valid_q, valid_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [2*DATA_W-1:0] hilo_q, hilo_d;
  logic                se, sm;

  assign se    = stall[STALL_IDX];
  assign sm    = stall[STALL_IDX+1];
  assign ex_in = '{wd: ex_wd, wreg: ex_wreg, wdata: ex_wdata, whilo: ex_whilo,
                   hi: ex_hi, lo: ex_lo};

  // Only the EX and MEM stall bits matter here. The other stall bits are ignored.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Next-state selection. Flush has priority.
  // When EX is not stalled, the instruction advances even if MEM is stalled.
  // That case is illegal from ctrl, but the behaviour is still defined.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    hilo_d  = hilo_q;
    if (flush) begin
      mem_d   = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      hilo_d  = '0;
    end else if (!se) begin
      mem_d   = ex_in;
      valid_d = 1'b1;
      cnt_d   = '0;
      hilo_d  = '0;
    end else if (!sm) begin
      // Bubble: EX is self-stalling, so the madd/msub progress loops back to it.
      mem_d   = '0;
      valid_d = 1'b0;
      cnt_d   = ex_cnt;
      hilo_d  = ex_hilo_temp;
    end
    // se && sm: hold everything
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      hilo_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      hilo_q  <= hilo_d;
    end
  end

  assign mem_wd    = mem_q.wd;
  assign mem_wreg  = mem_q.wreg;
  assign mem_wdata = mem_q.wdata;
  assign mem_whilo = mem_q.whilo;
  assign mem_hi    = mem_q.hi;
  assign mem_lo    = mem_q.lo;
  assign mem_valid = valid_q;
  assign cnt_o     = cnt_q;
  assign hilo_o    = hilo_q;

`ifdef EX_MEM_STAT_EN
  logic        is_bubble, is_hold;
  logic [31:0] bubble_cnt_q, bubble_cnt_d, hold_cnt_q, hold_cnt_d;

  // Flush cycles are counted as neither a bubble nor a hold.
  assign is_bubble = !flush && se && !sm;
  assign is_hold   = !flush && se && sm;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    if (is_bubble && bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (is_hold   && hold_cnt_q   != 32'hFFFF_FFFF) hold_cnt_d   = hold_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= '0;
      hold_cnt_q   <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign hold_cnt   = hold_cnt_q;
`else
  assign bubble_cnt = 32'h0;
  assign hold_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        valid;
    logic [1:0]  cnt;
    logic [63:0] hilo;
    logic [31:0] bub;
    logic [31:0] hld;
  } out_t;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [5:0]  stall;
  logic [4:0]  ex_wd;
  logic        ex_wreg, ex_whilo;
  logic [31:0] ex_wdata, ex_hi, ex_lo;
  logic [1:0]  ex_cnt;
  logic [63:0] ex_hilo_temp;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo, mem_valid;
  logic [31:0] mem_wdata, mem_hi, mem_lo, bubble_cnt, hold_cnt;
  logic [1:0]  cnt_o;
  logic [63:0] hilo_o;

  out_t obs, exp_o, m;
  out_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_cnt(ex_cnt), .ex_hilo_temp(ex_hilo_temp),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_valid(mem_valid), .cnt_o(cnt_o),
    .hilo_o(hilo_o), .bubble_cnt(bubble_cnt), .hold_cnt(hold_cnt)
  );

  assign obs = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_valid,
                cnt_o, hilo_o, bubble_cnt, hold_cnt};

  // Drive one cycle of stimulus at the negedge and push the expected result.
  // Then return 1 time unit after the following posedge.
  task automatic drive(input logic r, input logic f, input logic [5:0] s,
                       input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [1:0] cnt, input logic [63:0] ht);
    @(negedge clk);
    rst = r; flush = f; stall = s; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
    ex_whilo = whilo; ex_hi = hi; ex_lo = lo; ex_cnt = cnt; ex_hilo_temp = ht;
    if (r) m = '0;
    else if (f) begin
      m.wd = '0; m.wreg = 0; m.wdata = '0; m.whilo = 0; m.hi = '0; m.lo = '0;
      m.valid = 0; m.cnt = '0; m.hilo = '0;
    end else if (!s[3]) begin
      m.wd = wd; m.wreg = wreg; m.wdata = wdata; m.whilo = whilo; m.hi = hi; m.lo = lo;
      m.valid = 1; m.cnt = '0; m.hilo = '0;
    end else if (!s[4]) begin
      m.wd = '0; m.wreg = 0; m.wdata = '0; m.whilo = 0; m.hi = '0; m.lo = '0;
      m.valid = 0; m.cnt = cnt; m.hilo = ht;
`ifdef EX_MEM_STAT_EN
      if (m.bub != 32'hFFFF_FFFF) m.bub = m.bub + 1;
`endif
    end else begin
`ifdef EX_MEM_STAT_EN
      if (m.hld != 32'hFFFF_FFFF) m.hld = m.hld + 1;
`endif
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, $urandom_range(0, 1), 6'($urandom), 5'($urandom), 1'($urandom), $urandom,
            1'($urandom), $urandom, $urandom, 2'($urandom), {$urandom, $urandom});
      exp_o = sb.pop_front(); n_tests++;
      if (obs !== exp_o) begin
        n_fail++; $display("FAIL reset[%0d] got %h exp %h", i, obs, exp_o);
      end
    end
    n_tests++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_zero got %h exp 0", obs); end
  endtask

  task automatic test_advance();
    drive(0, 0, 6'b0, 5'd3, 1, 32'hDEADBEEF, 0, 0, 0, 2'b11, 64'h55);
    exp_o = sb.pop_front(); n_tests++;
    if (obs !== exp_o) begin n_fail++; $display("FAIL advance_gpr got %h exp %h", obs, exp_o); end
    n_tests++;
    if ({mem_wd, mem_wreg, mem_wdata, mem_valid, cnt_o} !== {5'd3, 1'b1, 32'hDEADBEEF, 1'b1, 2'b0}) begin
      n_fail++; $display("FAIL advance_const got %h/%b/%h/%b", mem_wd, mem_wreg, mem_wdata, mem_valid);
    end
    drive(0, 0, 6'b0, 5'd0, 0, 32'h0, 1, 32'h1, 32'h2, 2'b00, 64'h0);
    exp_o = sb.pop_front(); n_tests++;
    if (obs !== exp_o) begin n_fail++; $display("FAIL advance_hilo got %h exp %h", obs, exp_o); end
    n_tests++;
    if ({mem_whilo, mem_hi, mem_lo} !== {1'b1, 32'h1, 32'h2}) begin
      n_fail++; $display("FAIL advance_hilo_const got %b %h %h exp 1 1 2", mem_whilo, mem_hi, mem_lo);
    end
  endtask

  task automatic test_bubble();
    drive(0, 0, 6'b001111, 5'd7, 1, 32'h1234, 1, 32'h9, 32'h8, 2'b01, 64'h1_0000_0002);
    exp_o = sb.pop_front(); n_tests++;
    if (obs !== exp_o) begin n_fail++; $display("FAIL bubble got %h exp %h", obs, exp_o); end
    n_tests++;
    if ({mem_valid, mem_wreg, cnt_o, hilo_o} !== {1'b0, 1'b0, 2'b01, 64'h1_0000_0002}) begin
      n_fail++; $display("FAIL bubble_const got v=%b w=%b cnt=%b hilo=%h", mem_valid, mem_wreg, cnt_o, hilo_o);
    end
    drive(0, 0, 6'b0, 5'd1, 0, 32'h5, 0, 0, 0, 2'b10, 64'hFF);
    exp_o = sb.pop_front(); n_tests++;
    if (obs !== exp_o || cnt_o !== 2'b0 || hilo_o !== 64'h0) begin
      n_fail++; $display("FAIL bubble_release got %h exp %h", obs, exp_o);
    end
  endtask

  task automatic test_hold();
    out_t snap;
    drive(1, 0, 6'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    void'(sb.pop_front());
    drive(0, 0, 6'b0, 5'd9, 1, 32'hCAFEF00D, 1, 32'hA, 32'hB, 2'b00, 64'h0);
    void'(sb.pop_front());
    snap = obs;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 6'b011111, 5'($urandom), 1'($urandom), $urandom, 1'($urandom),
            $urandom, $urandom, 2'($urandom), {$urandom, $urandom});
      exp_o = sb.pop_front(); n_tests++;
      if (obs !== exp_o) begin n_fail++; $display("FAIL hold[%0d] got %h exp %h", i, obs, exp_o); end
    end
    n_tests++;
    if ({mem_wd, mem_wdata, mem_valid} !== {snap.wd, snap.wdata, snap.valid}) begin
      n_fail++; $display("FAIL hold_frozen got %h %h exp %h %h", mem_wd, mem_wdata, snap.wd, snap.wdata);
    end
    n_tests++;
`ifdef EX_MEM_STAT_EN
    if (hold_cnt !== 32'd3) begin n_fail++; $display("FAIL hold_cnt got %0d exp 3", hold_cnt); end
`else
    if (hold_cnt !== 32'd0) begin n_fail++; $display("FAIL hold_cnt got %0d exp 0", hold_cnt); end
`endif
  endtask

  task automatic test_flush();
    drive(0, 0, 6'b001111, 0, 0, 0, 0, 0, 0, 2'b10, 64'h77);
    void'(sb.pop_front());
    drive(0, 1, 6'b001111, 5'd4, 1, 32'h44, 1, 32'h1, 32'h1, 2'b01, 64'h1234);
    exp_o = sb.pop_front(); n_tests++;
    if (obs !== exp_o) begin n_fail++; $display("FAIL flush got %h exp %h", obs, exp_o); end
    n_tests++;
    if ({mem_wreg, mem_valid, cnt_o, hilo_o} !== '0) begin
      n_fail++; $display("FAIL flush_const got w=%b v=%b cnt=%b hilo=%h", mem_wreg, mem_valid, cnt_o, hilo_o);
    end
  endtask

  task automatic test_stat_sat();
`ifdef EX_MEM_STAT_EN
    @(negedge clk);
    force dut.bubble_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_cnt_q;
    m.bub = 32'hFFFF_FFFE;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 6'b001111, 0, 0, 0, 0, 0, 0, 2'($urandom), {$urandom, $urandom});
      exp_o = sb.pop_front(); n_tests++;
      if (obs !== exp_o) begin n_fail++; $display("FAIL stat_bubble[%0d] got %h exp %h", i, obs, exp_o); end
    end
    n_tests++;
`ifdef EX_MEM_STAT_EN
    if (bubble_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL stat_sat got %h exp ffffffff", bubble_cnt); end
`else
    if (bubble_cnt !== 32'h0) begin n_fail++; $display("FAIL stat_off got %h exp 0", bubble_cnt); end
`endif
    drive(1, 0, 6'b001111, 0, 0, 0, 0, 0, 0, 0, 0);
    exp_o = sb.pop_front(); n_tests++;
    if (obs !== exp_o || bubble_cnt !== 32'h0) begin
      n_fail++; $display("FAIL stat_rst got %h exp %h", obs, exp_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] s;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0, 1: s = 6'b000000;
        2:    s = 6'b001000;
        3:    s = 6'b011000;
        default: s = 6'b010000;  // MEM stalled without EX stall: still advances
      endcase
      s = s | (6'($urandom) & 6'b100111);
      drive(0, ($urandom_range(0, 7) == 0), s, 5'($urandom), 1'($urandom), $urandom,
            1'($urandom), $urandom, $urandom, 2'($urandom), {$urandom, $urandom});
      exp_o = sb.pop_front(); n_tests++;
      if (obs !== exp_o) begin n_fail++; $display("FAIL b2b[%0d] got %h exp %h", i, obs, exp_o); end
    end
  endtask

  initial begin
    m = '0;
    rst = 1; flush = 0; stall = '0; ex_wd = '0; ex_wreg = 0; ex_wdata = '0; ex_whilo = 0;
    ex_hi = '0; ex_lo = '0; ex_cnt = '0; ex_hilo_temp = '0;
    test_reset();
    test_advance();
    test_bubble();
    test_hold();
    test_flush();
    test_stat_sat();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
